data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//  Data-memory responder for the RV32I pipelined core's load/store port: accepts one request at a time
//  over a valid/ready handshake and returns a response a fixed LATENCY cycles later.
//  - Performs byte/half/word writes and sign/zero-extended loads, selected by funct3.
//  - Sits on the core's memory-stage bus; the hazard unit stalls while req_ready or rsp_valid is pending.
// PARAMETERS
//  DEPTH    1024  number of 32-bit words; index = req_addr[$clog2(DEPTH)+1:2], upper bits ignored (wrap)
//  LATENCY  2     cycles from accept to rsp_valid; legal range 1..15
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  req_valid  in   1   request present
//  req_ready  out  1   responder idle, request accepted when req_valid & req_ready
//  req_we     in   1   1 = store, 0 = load
//  req_funct3 in   3   access size/sign, RISC-V load/store funct3 encoding
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data, LSB-aligned (sb uses [7:0], sh uses [15:0])
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   core takes response
//  rsp_rdata  out  32  load result, extended; 0 for stores and errors
//  rsp_err    out  1   illegal funct3 (or misaligned, see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
//    Memory array is not cleared. Reset mid-operation drops the pending request; a pending store is not committed.
//  - FSM IDLE -> BUSY on accept: latch we/funct3/addr/wdata; counter loads LATENCY-1.
//  - BUSY: counter decrements each cycle; at 0 -> RESP.
//    LATENCY=1 skips BUSY (IDLE -> RESP), so rsp_valid rises exactly LATENCY cycles after the accept edge.
//  - Store commits to the array on the edge entering RESP. Read data is sampled from the array on that same edge.
//  - RESP: rsp_valid=1, outputs stable until rsp_valid & rsp_ready; then -> IDLE. rsp_ready may be high on arrival (1-cycle RESP).
//  - req_ready=1 only in IDLE; no acceptance in RESP even if rsp_ready=1.
//    Peak throughput: 1 request per LATENCY+1 cycles.
//  - Stores: funct3 000 sb writes lane addr[1:0]; 001 sh writes lanes {addr[1],0},+1; 010 sw writes all 4 lanes.
//  - Loads: 000 lb, 001 lh sign-extend; 100 lbu, 101 lhu zero-extend; 010 lw raw.
//    Byte lane = addr[1:0]; half lane = addr[1]; word ignores addr[1:0].
//  - Illegal funct3 (load 011/110/111; store any except 000/001/010): rsp_err=1, rsp_rdata=0, no array write,
//    same latency as a legal access.
//  - req_* inputs are ignored outside the accept cycle.
// CONFIGURATION
//  - MISALIGN_TRAP_EN defined: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0 -> rsp_err=1, rsp_rdata=0,
//    no write, normal latency.
//  - MISALIGN_TRAP_EN undefined: low address bits are truncated as described above; rsp_err only for illegal funct3.
// STRUCTURE
//  - Shared package mem_pkg: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the FSM state encoding
//    (S_IDLE, S_BUSY, S_RESP).
//  - One sub-module mem_lane_ctrl (combinational): funct3 + addr[1:0] + wdata ->
//    4-bit byte-enable, lane-shifted wdata, extended rdata, err flag.
//  - Top holds the FSM, counter, request latches and the array.
// TESTING
//  - Reset mid-BUSY: accept sw 0xDEADBEEF @0x10, assert rst before RESP
//    -> rsp_valid stays 0, then lw @0x10 returns prior contents, not 0xDEADBEEF.
//  - LATENCY=2: accept at cycle t -> rsp_valid=1 at t+2; req_ready=0 at t+1..t+2; rsp_ready held low 3 cycles -> rsp_rdata stable.
//  - sw 0x8081_7F01 @0x20; lb @0x20 -> 0x00000001; lb @0x23 -> 0xFFFFFF80;
//    lbu @0x23 -> 0x00000080; lh @0x22 -> 0xFFFF8081.
//  - sb 0xAA @0x21 after sw 0x11223344 @0x20 -> lw @0x20 = 0x1122AA44.
//  - Illegal load funct3=011 -> rsp_err=1, rsp_rdata=0; store funct3=100 -> rsp_err=1, word unchanged.
//  - MISALIGN_TRAP_EN: lw @0x21 -> rsp_err=1. Without the macro: lw @0x21 returns word @0x20, rsp_err=0.
//    Both builds: address DEPTH*4 aliases to 0x0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings, FSM states
// and the funct3 legality rule.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Stores only come in b/h/w; loads add the unsigned b/h variants.
    function automatic logic is_legal_f3(input logic we, input logic [2:0] funct3);
        if (we)
            return funct3 inside {F3_B, F3_H, F3_W};
        else
            return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

endpackage

// File: rtl/mem_lane_ctrl.sv
// Combinational lane steering: byte enables and lane-replicated store data, extended
// load data and the error flag. MISALIGN_TRAP_EN turns misaligned h/w accesses into errors.
module mem_lane_ctrl
    import mem_pkg::*;
(
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_err;

    assign w_byte = i_rword[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

`ifdef MISALIGN_TRAP_EN
    logic w_misalign;

    always_comb begin
        w_misalign = 1'b0;
        case (i_funct3)
            F3_H, F3_HU: w_misalign = i_addr_lo[0];
            F3_W:        w_misalign = |i_addr_lo;
            default:     w_misalign = 1'b0;
        endcase
    end

    assign w_err = !is_legal_f3(i_we, i_funct3) || w_misalign;
`else
    assign w_err = !is_legal_f3(i_we, i_funct3);
`endif

    assign o_err = w_err;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
        o_be    = 4'b0000;
        o_wdata = 32'h0;
        o_rdata = 32'h0;
        if (!w_err) begin
            if (i_we) begin
                // Store data is replicated across lanes; the byte enables pick the target lane(s).
                case (i_funct3)
                    F3_B: begin
                        o_be    = 4'b0001 << i_addr_lo;
                        o_wdata = {4{i_wdata[7:0]}};
                    end
                    F3_H: begin
                        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                        o_wdata = {2{i_wdata[15:0]}};
                    end
                    default: begin
                        o_be    = 4'b1111;
                        o_wdata = i_wdata;
                    end
                endcase
            end else begin
                case (i_funct3)
                    F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
                    F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
                    F3_BU:   o_rdata = {24'h0, w_byte};
                    F3_HU:   o_rdata = {16'h0, w_half};
                    default: o_rdata = i_rword;
                endcase
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder for the core's load/store port (one request in flight).
// Optional MISALIGN_TRAP_EN (see mem_lane_ctrl) reports misaligned h/w accesses as errors.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW     = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t        r_state, w_next_state;
    logic [3:0]    r_cnt, w_next_cnt;

    logic          r_we;
    logic [2:0]    r_funct3;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;

    logic          w_we;
    logic [2:0]    w_funct3;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic [AW-1:0] w_idx;
    logic          w_unused_addr_hi;

    logic [31:0]   r_mem [DEPTH];
    logic [3:0]    w_be;
    logic [31:0]   w_wdata_lane;
    logic [31:0]   w_rdata_ext;
    logic          w_err;
    logic          w_enter_resp;

    logic [31:0]   r_rsp_rdata;
    logic          r_rsp_err;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop updates from pre-edge values.
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (LAT_M1 == 4'd0) begin
                        w_next_state = S_RESP;
                    end else begin
                        w_next_state = S_BUSY;
                        w_next_cnt   = LAT_M1;
                    end
                end
            end
            S_BUSY: begin
                w_next_cnt = r_cnt - 4'd1;
                if (r_cnt == 4'd1)
                    w_next_state = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
        end else if (r_state == S_IDLE && req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
        end
    end

    // With LATENCY=1 the access completes on the accept edge, before the latches hold the request.
    assign w_we     = (r_state == S_IDLE) ? req_we     : r_we;
    assign w_funct3 = (r_state == S_IDLE) ? req_funct3 : r_funct3;
    assign w_addr   = (r_state == S_IDLE) ? req_addr   : r_addr;
    assign w_wdata  = (r_state == S_IDLE) ? req_wdata  : r_wdata;

    // Upper address bits wrap onto the array.
    assign w_idx            = w_addr[AW+1:2];
    assign w_unused_addr_hi = ^w_addr[31:AW+2];

    assign w_enter_resp = (w_next_state == S_RESP) && (r_state != S_RESP);

    mem_lane_ctrl u_lane_ctrl (
        .i_we      (w_we),
        .i_funct3  (w_funct3),
        .i_addr_lo (w_addr[1:0]),
        .i_wdata   (w_wdata),
        .i_rword   (r_mem[w_idx]),
        .o_be      (w_be),
        .o_wdata   (w_wdata_lane),
        .o_rdata   (w_rdata_ext),
        .o_err     (w_err)
    );

    // NOTE: the array has no reset so it maps onto RAM; rst only blocks a commit on a reset edge.
    always_ff @(posedge clk) begin
        if (w_enter_resp && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b])
                    r_mem[w_idx][8*b +: 8] <= w_wdata_lane[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else if (w_enter_resp) begin
            r_rsp_rdata <= w_rdata_ext;
            r_rsp_err   <= w_err;
        end else if (r_state == S_RESP && rsp_ready) begin
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end
    end

    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule
